// File: rtl/stack_push_pkg.sv
// Purpose : shared 6502 stack definitions (push-state encoding, stack page, SP reset value).
// Latency : n/a (types, constants and a helper only).
// Backpressure : n/a. Also reused by the pull (RTS/RTI) sequencer.
package stack_push_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PUSH_H = 2'd1,
      ST_PUSH_L = 2'd2,
      ST_PUSH_P = 2'd3
   } push_state_e;

   localparam logic [7:0] SP_RESET_DEF   = 8'hFD;
   localparam logic [7:0] STACK_PAGE_DEF = 8'h01;

   // The stack grows downward; wrapping from 8'h00 to 8'hFF is silent.
   function automatic logic [7:0] sp_dec(input logic [7:0] v);
      return v - 8'd1;
   endfunction

endpackage

// File: rtl/stack_push_if.sv
// Purpose : bundles the request/snapshot inputs and the stack-write bus of stack_push.
// Latency : n/a (wires only).
// Backpressure : none. The master holds requests; the slave ignores them while busy.
// Ports : master = core sequencer (drives start/pc/p/sp_load), slave = stack_push.
interface stack_push_if;
   logic       start;
   logic       push_p;
   logic [7:0] pc_hi;
   logic [7:0] pc_lo;
   logic [7:0] p_in;
   logic       sp_load;
   logic [7:0] sp_data;
   logic [7:0] addr_hi;
   logic [7:0] addr_lo;
   logic [7:0] data_out;
   logic       we;
   logic       busy;
   logic       done;
   logic [7:0] sp;

   modport master (
      output start, push_p, pc_hi, pc_lo, p_in, sp_load, sp_data,
      input  addr_hi, addr_lo, data_out, we, busy, done, sp
   );

   modport slave (
      input  start, push_p, pc_hi, pc_lo, p_in, sp_load, sp_data,
      output addr_hi, addr_lo, data_out, we, busy, done, sp
   );
endinterface

// File: rtl/stack_push.sv
// Purpose : pushes PC high and low bytes (plus P, optionally) to page-1 stack; owns SP and the TXS load.
// Latency : the first write is in the cycle after the start edge. Writes are back to back; done follows the last write.
// Backpressure : none. Requests are ignored while busy, and the inputs are snapshotted at start.
// Ports : clk (falling-edge state update), rst_n (async active-low), bus (stack_push_if.slave).
module stack_push
   import stack_push_pkg::*;
#(
   parameter logic [7:0] SP_RESET   = SP_RESET_DEF,
   parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   stack_push_if.slave  bus
);

   push_state_e state_q;
   logic [7:0]  sp_q, sp_d;
   logic [7:0]  data_q;
   logic        we_q;
   logic        busy_q;
   logic        done_q;
   // Snapshot of the later bytes. pc_hi is loaded straight into data_q at start.
   logic [7:0]  pcl_q;
   logic [7:0]  p_q;
   logic        pushp_q;

   // The address low byte always equals SP. Every push state decrements on exit.
   // So the write address is always the SP value held for that cycle.
   always_comb begin
      sp_d = sp_q;
      unique case (state_q)
         ST_IDLE:   if (bus.sp_load) sp_d = bus.sp_data;
         default:   sp_d = sp_dec(sp_q);
      endcase
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sp_q    <= SP_RESET;
         data_q  <= 8'h00;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pcl_q   <= 8'h00;
         p_q     <= 8'h00;
         pushp_q <= 1'b0;
      end else begin
         sp_q   <= sp_d;
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               // sp_load wins over start on the same edge.
               if (!bus.sp_load && bus.start) begin
                  pcl_q   <= bus.pc_lo;
                  p_q     <= bus.p_in;
                  pushp_q <= bus.push_p;
                  data_q  <= bus.pc_hi;
                  we_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= ST_PUSH_H;
               end
            end
            ST_PUSH_H: begin
               data_q  <= pcl_q;
               state_q <= ST_PUSH_L;
            end
            ST_PUSH_L: begin
               if (pushp_q) begin
                  data_q  <= p_q;
                  state_q <= ST_PUSH_P;
               end else begin
                  data_q  <= 8'h00;
                  we_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            ST_PUSH_P: begin
               data_q  <= 8'h00;
               we_q    <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.addr_hi  = STACK_PAGE;
   assign bus.addr_lo  = sp_q;
   assign bus.sp       = sp_q;
   assign bus.data_out = data_q;
   assign bus.we       = we_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_stack_push.sv
// Purpose : self-checking bench for stack_push (directed vector table, reset corner, random vs queue model).
// Latency : the DUT updates on the falling edge; the bench drives just after the rising edge and checks on it.
// Backpressure : n/a.
module tb_stack_push;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   stack_push_if bus();

   stack_push dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   typedef struct {
      logic       st;
      logic       pp;
      logic [7:0] ph;
      logic [7:0] pl;
      logic [7:0] p;
      logic       ld;
      logic [7:0] sd;
      logic       e_we;
      logic [7:0] e_data;
      logic [7:0] e_alo;
      logic       e_busy;
      logic       e_done;
   } vec_t;

   vec_t vecs[22];

   function automatic vec_t mk(logic st, logic pp, logic [7:0] ph, logic [7:0] pl, logic [7:0] p,
                               logic ld, logic [7:0] sd, logic e_we, logic [7:0] e_data,
                               logic [7:0] e_alo, logic e_busy, logic e_done);
      vec_t v;
      v.st = st; v.pp = pp; v.ph = ph; v.pl = pl; v.p = p; v.ld = ld; v.sd = sd;
      v.e_we = e_we; v.e_data = e_data; v.e_alo = e_alo; v.e_busy = e_busy; v.e_done = e_done;
      return v;
   endfunction

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic st, logic pp, logic [7:0] ph, logic [7:0] pl, logic [7:0] p,
                        logic ld, logic [7:0] sd);
      bus.start   = st;
      bus.push_p  = pp;
      bus.pc_hi   = ph;
      bus.pc_lo   = pl;
      bus.p_in    = p;
      bus.sp_load = ld;
      bus.sp_data = sd;
   endtask

   // Waits for the next rising edge (mid-cycle), compares all outputs, then steps 1 time unit past it.
   task automatic expect_cycle(string tag, logic e_we, logic [7:0] e_data, logic [7:0] e_alo,
                               logic e_busy, logic e_done);
      @(posedge clk);
      chk({tag, ".we"},   {7'd0, bus.we},   {7'd0, e_we});
      chk({tag, ".data"}, bus.data_out,     e_data);
      chk({tag, ".ahi"},  bus.addr_hi,      8'h01);
      chk({tag, ".alo"},  bus.addr_lo,      e_alo);
      chk({tag, ".sp"},   bus.sp,           e_alo);
      chk({tag, ".busy"}, {7'd0, bus.busy}, {7'd0, e_busy});
      chk({tag, ".done"}, {7'd0, bus.done}, {7'd0, e_done});
      #1;
   endtask

   // Reference model: a queue of the bytes still to be written this sequence.
   // One byte is retired per edge, and SP falls with each retired byte.
   logic [7:0] mq[$];
   logic [7:0] m_sp;
   logic       m_done;

   task automatic model_step(logic st, logic pp, logic [7:0] ph, logic [7:0] pl, logic [7:0] p,
                             logic ld, logic [7:0] sd);
      if (mq.size() != 0) begin
         void'(mq.pop_front());
         m_sp   = m_sp - 8'd1;
         m_done = (mq.size() == 0);
      end else begin
         m_done = 1'b0;
         if (ld) m_sp = sd;
         else if (st) begin
            mq.push_back(ph);
            mq.push_back(pl);
            if (pp) mq.push_back(p);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00);

      // Directed per-cycle vectors; each row is applied just before the falling edge that samples it.
      // C123 push without P from SP=FD.
      vecs[0]  = mk(0,0,8'h00,8'h00,8'h00,0,8'h00, 0,8'h00,8'hFD,0,0);
      vecs[1]  = mk(1,0,8'hC1,8'h23,8'h00,0,8'h00, 1,8'hC1,8'hFD,1,0);
      vecs[2]  = mk(0,0,8'h00,8'h00,8'h00,0,8'h00, 1,8'h23,8'hFC,1,0);
      vecs[3]  = mk(0,0,8'h00,8'h00,8'h00,0,8'h00, 0,8'h00,8'hFB,0,1);
      vecs[4]  = mk(0,0,8'h00,8'h00,8'h00,0,8'h00, 0,8'h00,8'hFB,0,0);
      // TXS to 01, then a three-byte push wrapping through 00 to FF.
      vecs[5]  = mk(0,0,8'h00,8'h00,8'h00,1,8'h01, 0,8'h00,8'h01,0,0);
      vecs[6]  = mk(1,1,8'h80,8'h00,8'h34,0,8'h00, 1,8'h80,8'h01,1,0);
      vecs[7]  = mk(0,0,8'h00,8'h00,8'h00,0,8'h00, 1,8'h00,8'h00,1,0);
      vecs[8]  = mk(0,0,8'h00,8'h00,8'h00,0,8'h00, 1,8'h34,8'hFF,1,0);
      vecs[9]  = mk(0,0,8'h00,8'h00,8'h00,0,8'h00, 0,8'h00,8'hFE,0,1);
      // start together with sp_load: the load wins and no write follows.
      vecs[10] = mk(1,0,8'h11,8'h11,8'h00,1,8'h40, 0,8'h00,8'h40,0,0);
      // Inputs disturbed mid-sequence must not leak into the pushed bytes.
      vecs[11] = mk(1,0,8'hAA,8'hBB,8'h00,0,8'h00, 1,8'hAA,8'h40,1,0);
      vecs[12] = mk(0,0,8'h55,8'h66,8'h00,1,8'h99, 1,8'hBB,8'h3F,1,0);
      vecs[13] = mk(1,1,8'h77,8'h88,8'h12,1,8'h99, 0,8'h00,8'h3E,0,1);
      vecs[14] = mk(0,0,8'h00,8'h00,8'h00,0,8'h00, 0,8'h00,8'h3E,0,0);
      // start held high: PUSH_H, PUSH_L, IDLE(done), PUSH_H ...
      vecs[15] = mk(1,0,8'h12,8'h34,8'h00,0,8'h00, 1,8'h12,8'h3E,1,0);
      vecs[16] = mk(1,0,8'h56,8'h78,8'h00,0,8'h00, 1,8'h34,8'h3D,1,0);
      vecs[17] = mk(1,0,8'h56,8'h78,8'h00,0,8'h00, 0,8'h00,8'h3C,0,1);
      vecs[18] = mk(1,0,8'h56,8'h78,8'h00,0,8'h00, 1,8'h56,8'h3C,1,0);
      vecs[19] = mk(1,0,8'h56,8'h78,8'h00,0,8'h00, 1,8'h78,8'h3B,1,0);
      vecs[20] = mk(0,0,8'h00,8'h00,8'h00,0,8'h00, 0,8'h00,8'h3A,0,1);
      vecs[21] = mk(0,0,8'h00,8'h00,8'h00,0,8'h00, 0,8'h00,8'h3A,0,0);

      // Reset state, seen after a falling edge with reset held low.
      expect_cycle("reset", 0, 8'h00, 8'hFD, 0, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++) begin
         drive(vecs[i].st, vecs[i].pp, vecs[i].ph, vecs[i].pl, vecs[i].p, vecs[i].ld, vecs[i].sd);
         expect_cycle($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_data, vecs[i].e_alo,
                      vecs[i].e_busy, vecs[i].e_done);
      end

      // Reset during PUSH_L: outputs fall at once, without waiting for a clock edge.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      drive(1, 1, 8'hAB, 8'hCD, 8'hEE, 0, 8'h00);
      expect_cycle("mr_h", 1, 8'hAB, 8'hFD, 1, 0);
      drive(0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
      expect_cycle("mr_l", 1, 8'hCD, 8'hFC, 1, 0);
      rst_n = 1'b0;
      #1;
      chk("mr_async.we",   {7'd0, bus.we},   8'h00);
      chk("mr_async.busy", {7'd0, bus.busy}, 8'h00);
      chk("mr_async.sp",   bus.sp,           8'hFD);
      chk("mr_async.alo",  bus.addr_lo,      8'hFD);
      chk("mr_async.data", bus.data_out,     8'h00);
      expect_cycle("mr_hold", 0, 8'h00, 8'hFD, 0, 0);
      rst_n = 1'b1;
      drive(1, 0, 8'h9A, 8'hBC, 8'h00, 0, 8'h00);
      expect_cycle("mr_new_h", 1, 8'h9A, 8'hFD, 1, 0);
      drive(0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
      expect_cycle("mr_new_l", 1, 8'hBC, 8'hFC, 1, 0);
      expect_cycle("mr_new_d", 0, 8'h00, 8'hFB, 0, 1);

      // Random traffic against the queue model, starting from a fresh reset.
      rst_n = 1'b0;
      expect_cycle("rr", 0, 8'h00, 8'hFD, 0, 0);
      rst_n = 1'b1;
      mq.delete();
      m_sp   = 8'hFD;
      m_done = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         logic       st, pp, ld, e_we;
         logic [7:0] ph, pl, p, sd, e_data;
         st = ($urandom_range(0, 2) == 0);
         pp = $urandom_range(0, 1) == 1;
         ld = ($urandom_range(0, 7) == 0);
         ph = 8'($urandom);
         pl = 8'($urandom);
         p  = 8'($urandom);
         sd = 8'($urandom);
         drive(st, pp, ph, pl, p, ld, sd);
         model_step(st, pp, ph, pl, p, ld, sd);
         e_we   = (mq.size() != 0);
         e_data = e_we ? mq[0] : 8'h00;
         expect_cycle("rnd", e_we, e_data, m_sp, e_we, m_done);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
